// File: rtl/playback_sequencer_if.sv
// ============================================================================
// Module      : playback_sequencer_if
// Description : Memory-side bus between the playback sequencer and song memory.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface playback_sequencer_if #(
  parameter int SEL_W      = 2,
  parameter int DATA_WIDTH = 8
);
  logic [SEL_W-1:0]      mem_select;
  logic                  mem_read_en;
  logic                  mem_read_rst;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ready;

  modport master (
    output mem_select, mem_read_en, mem_read_rst,
    input  mem_data, mem_ready
  );

  modport slave (
    input  mem_select, mem_read_en, mem_read_rst,
    output mem_data, mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/playback_sequencer.sv
// ============================================================================
// Module      : playback_sequencer
// Description : Fetches note words from song memory and plays them with timed
//               durations and gaps. Macro SEQ_LOOP_EN replays the song forever.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module playback_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int DUR_W      = 3,
  parameter int SEL_W      = 2,
  parameter int TICK_DIV   = 12500000,
  parameter int GAP_CYC    = 1250000,
  parameter int TIMEOUT    = 16
) (
  input  wire                          clk,
  input  wire                          rst,
  input  wire                          start_i,
  input  wire                          stop_i,
  input  wire                          pause_i,
  input  wire [SEL_W-1:0]              song_sel_i,
  input  wire [SEL_W:0]                song_count_i,
  playback_sequencer_if.master         mem,
  output logic [DATA_WIDTH-DUR_W-1:0]  note_out_o,
  output logic                         note_valid_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int NOTE_W  = DATA_WIDTH - DUR_W;
  localparam int DUR_MAX = (2 ** DUR_W) * TICK_DIV;
  localparam int CNT_MAX = (DUR_MAX > GAP_CYC) ? DUR_MAX : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REWIND   = 3'd1,
    S_FETCH    = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_PLAY     = 3'd4,
    S_GAP      = 3'd5,
    S_PAUSED   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  state_t              resume_q, resume_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      resume_q <= S_IDLE;
      cnt_q    <= '0;
      to_q     <= '0;
      sel_q    <= '0;
      note_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      sel_q    <= sel_d;
      note_q   <= note_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    sel_d    = sel_q;
    note_d   = note_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if ({1'b0, song_sel_i} < song_count_i) begin
            sel_d   = song_sel_i;
            state_d = S_REWIND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_REWIND: state_d = S_FETCH;
      S_FETCH: begin
        to_d    = '0;
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (mem.mem_ready) begin
          if (mem.mem_data == '0) begin
            done_d = 1'b1;
`ifdef SEQ_LOOP_EN
            state_d = S_REWIND;
`else
            state_d = S_IDLE;
`endif
          end else begin
            note_d  = mem.mem_data[NOTE_W-1:0];
            cnt_d   = (CNT_W'(mem.mem_data[DATA_WIDTH-1 -: DUR_W]) + CNT_W'(1))
                      * CNT_W'(TICK_DIV);
            state_d = S_PLAY;
          end
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_PLAY, S_GAP: begin
        if (cnt_q == CNT_W'(1)) begin
          if (state_q == S_PLAY && GAP_CYC != 0) begin
            cnt_d   = CNT_W'(GAP_CYC);
            state_d = S_GAP;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        // The pause cycle still counts as played; resume where the count left off.
        if (pause_i) begin
          resume_d = state_d;
          state_d  = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause_i) state_d = resume_q;
      end
      default: state_d = S_IDLE;
    endcase

    if (stop_i) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  assign mem.mem_select   = sel_q;
  assign mem.mem_read_rst = (state_q == S_REWIND);
  assign mem.mem_read_en  = (state_q == S_FETCH);
  assign note_out_o       = note_q;
  assign note_valid_o     = (state_q == S_PLAY);
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

`default_nettype wire

// File: tb/tb_playback_sequencer.sv
// ============================================================================
// Module      : tb_playback_sequencer
// Description : Directed self-checking bench for playback_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_playback_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, pause;
  logic [1:0] song_sel;
  logic [2:0] song_count;
  logic [4:0] note_out;
  logic       note_valid, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  playback_sequencer_if #(.SEL_W(2), .DATA_WIDTH(8)) mif ();

  playback_sequencer #(
    .DATA_WIDTH(8), .DUR_W(3), .SEL_W(2),
    .TICK_DIV(4), .GAP_CYC(2), .TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .stop_i       (stop),
    .pause_i      (pause),
    .song_sel_i   (song_sel),
    .song_count_i (song_count),
    .mem          (mif),
    .note_out_o   (note_out),
    .note_valid_o (note_valid),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives a song start through REWIND/FETCH and answers with one word;
  // returns at the first PLAY cycle.
  task automatic start_song(input logic [1:0] sel, input logic [2:0] cnt,
                            input logic [7:0] word);
    start = 1'b1; song_sel = sel; song_count = cnt;
    tick;
    start = 1'b0;
    tick;
    tick;
    mif.mem_ready = 1'b1; mif.mem_data = word;
    tick;
    mif.mem_ready = 1'b0; mif.mem_data = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_tests++;
    if ({busy, note_valid, done, err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, note_valid, done, err});
    end
    n_tests++;
    if ({mif.mem_read_en, mif.mem_read_rst} !== 2'b00) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 00", {mif.mem_read_en, mif.mem_read_rst});
    end
    n_tests++;
    if (note_out !== 5'd0 || mif.mem_select !== 2'd0) begin
      n_fail++; $display("FAIL reset_regs: note %0h sel %0d expected 0 0", note_out, mif.mem_select);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_play;
    int hi, lo;
    start = 1'b1; song_sel = 2'd1; song_count = 3'd2;
    tick;
    start = 1'b0;
    n_tests++;
    if ({mif.mem_read_rst, mif.mem_read_en, busy} !== 3'b101 || mif.mem_select !== 2'd1) begin
      n_fail++; $display("FAIL play_rewind: rst/en/busy %b sel %0d expected 101 sel 1",
                         {mif.mem_read_rst, mif.mem_read_en, busy}, mif.mem_select);
    end
    tick;
    n_tests++;
    if ({mif.mem_read_rst, mif.mem_read_en} !== 2'b01) begin
      n_fail++; $display("FAIL play_fetch: rst/en %b expected 01", {mif.mem_read_rst, mif.mem_read_en});
    end
    tick;
    n_tests++;
    if (mif.mem_read_en !== 1'b0) begin
      n_fail++; $display("FAIL play_fetch_once: read_en %b expected 0", mif.mem_read_en);
    end
    mif.mem_ready = 1'b1; mif.mem_data = 8'h25;
    tick;
    mif.mem_ready = 1'b0; mif.mem_data = 8'h00;
    n_tests++;
    if (note_out !== 5'h05) begin
      n_fail++; $display("FAIL play_note: got %0h expected 05", note_out);
    end
    hi = 0;
    while (note_valid === 1'b1 && hi < 40) begin hi++; tick; end
    n_tests++;
    if (hi !== 8) begin
      n_fail++; $display("FAIL play_duration: got %0d expected 8", hi);
    end
    lo = 0;
    while (note_valid === 1'b0 && mif.mem_read_en !== 1'b1 && lo < 40) begin lo++; tick; end
    n_tests++;
    if (lo !== 2 || mif.mem_read_en !== 1'b1) begin
      n_fail++; $display("FAIL play_gap: got %0d cycles read_en %b expected 2 cycles read_en 1",
                         lo, mif.mem_read_en);
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
  endtask

  task automatic test_bad_select;
    logic [1:0] sels [3] = '{2'd3, 2'd2, 2'd0};
    logic [2:0] cnts [3] = '{3'd2, 3'd2, 3'd0};
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; song_sel = sels[i]; song_count = cnts[i];
      tick;
      start = 1'b0;
      n_tests++;
      if ({err, busy, mif.mem_read_en, mif.mem_read_rst} !== 4'b1000) begin
        n_fail++; $display("FAIL bad_sel_%0d: err/busy/en/rst %b expected 1000", i,
                           {err, busy, mif.mem_read_en, mif.mem_read_rst});
      end
      tick;
      n_tests++;
      if ({err, busy} !== 2'b00) begin
        n_fail++; $display("FAIL bad_sel_pulse_%0d: err/busy %b expected 00", i, {err, busy});
      end
    end
  endtask

  task automatic test_end_of_song;
    int k;
    start_song(2'd1, 3'd2, 8'h05);
    k = 0;
    while (mif.mem_read_en !== 1'b1 && k < 40) begin k++; tick; end
    tick;
    mif.mem_ready = 1'b1; mif.mem_data = 8'h00;
    tick;
    mif.mem_ready = 1'b0;
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL eos_done: got %b expected 1", done);
    end
`ifdef SEQ_LOOP_EN
    n_tests++;
    if ({busy, mif.mem_read_rst} !== 2'b11) begin
      n_fail++; $display("FAIL eos_loop: busy/read_rst %b expected 11", {busy, mif.mem_read_rst});
    end
`else
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL eos_idle: busy %b expected 0", busy);
    end
`endif
    tick;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL eos_done_pulse: got %b expected 0", done);
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
  endtask

  task automatic test_timeout;
    int k;
    start = 1'b1; song_sel = 2'd0; song_count = 3'd1;
    tick;
    start = 1'b0;
    tick;
    k = 0;
    tick;
    while (err !== 1'b1 && k < 40) begin k++; tick; end
    n_tests++;
    if (k !== 16 || err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_len: got %0d cycles err %b expected 16 err 1", k, err);
    end
    n_tests++;
    if ({busy, note_valid} !== 2'b00) begin
      n_fail++; $display("FAIL timeout_idle: busy/valid %b expected 00", {busy, note_valid});
    end
    tick;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse: err %b expected 0", err);
    end
  endtask

  task automatic test_pause;
    int bad, hi;
    pause = 1'b1;
    tick;
    pause = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL pause_idle: busy %b expected 0", busy);
    end
    start_song(2'd0, 3'd1, 8'h25);
    tick;
    tick;
    pause = 1'b1;
    tick;
    pause = 1'b0;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (note_valid !== 1'b0 || busy !== 1'b1) bad++;
      tick;
    end
    if (note_valid !== 1'b0 || busy !== 1'b1) bad++;
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL pause_hold: %0d bad cycles expected 0", bad);
    end
    pause = 1'b1;
    tick;
    pause = 1'b0;
    hi = 0;
    while (note_valid === 1'b1 && hi < 40) begin hi++; tick; end
    n_tests++;
    if (hi !== 5) begin
      n_fail++; $display("FAIL pause_remaining: got %0d expected 5", hi);
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
  endtask

  task automatic test_stop;
    start_song(2'd1, 3'd3, 8'h45);
    tick;
    start = 1'b1; song_sel = 2'd2;
    tick;
    start = 1'b0;
    n_tests++;
    if (mif.mem_select !== 2'd1 || mif.mem_read_rst !== 1'b0) begin
      n_fail++; $display("FAIL busy_start: sel %0d rst %b expected 1 0", mif.mem_select, mif.mem_read_rst);
    end
    stop = 1'b1; pause = 1'b1;
    tick;
    stop = 1'b0; pause = 1'b0;
    n_tests++;
    if ({busy, note_valid, done, err} !== 4'b0000) begin
      n_fail++; $display("FAIL stop_mid_play: busy/valid/done/err %b expected 0000",
                         {busy, note_valid, done, err});
    end
    tick;
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL stop_settled: busy/done %b expected 00", {busy, done});
    end
  endtask

  task automatic test_reset_mid_play;
    start_song(2'd2, 3'd3, 8'h3A);
    n_tests++;
    if (note_valid !== 1'b1 || note_out !== 5'h1A) begin
      n_fail++; $display("FAIL rst_pre_play: valid %b note %0h expected 1 1a", note_valid, note_out);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_tests++;
    if ({busy, note_valid, done, err} !== 4'b0000 || note_out !== 5'd0 || mif.mem_select !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid_play: flags %b note %0h sel %0d expected 0000 0 0",
                         {busy, note_valid, done, err}, note_out, mif.mem_select);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    song_sel = 2'd0; song_count = 3'd0;
    mif.mem_ready = 1'b0; mif.mem_data = 8'h00;
    test_reset;
    test_play;
    test_bad_select;
    test_end_of_song;
    test_timeout;
    test_pause;
    test_stop;
    test_reset_mid_play;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
